inst_decode_pipe: RTL and testbench
===================================

# inst_decode_pipe

Parametrised, elastic RV32/RV64 instruction-decode stage sitting between fetch and execute. It accepts instruction words and their PCs over a valid/ready handshake and buffers them in an internal queue. Each word is decoded through a configurable-depth register pipeline into register addresses, funct fields, a sign-extended immediate, a one-hot instruction type and an illegal flag. Outputs carry valid/ready backpressure, and the stage clears on pipeline flush.

## Interface
- XLEN, 32: data/PC width; 32 or 64.
- DEPTH, 4: input queue entries; power of two, 2..16.
- CYCLE_NUM, 2: decode register stages after the queue; 1..4.
- iClk  in  1  clock.
- iRst  in  1  reset; synchronous, active-high.
- iInst  in  32  instruction word.
- iCurPC  in  XLEN  PC of iInst.
- iValid  in  1  iInst/iCurPC valid.
- oReady  out  1  queue can accept this cycle.
- iFlushPipe  in  1  discard all queued and in-flight instructions.
- iReady  in  1  downstream accepts output.
- oValid  out  1  decoded outputs valid.
- oRs1Addr, oRs2Addr, oRdAddr  out  5 each  register addresses.
- oF3 / oF7  out  3 / 7  funct3 / funct7.
- oOpcode  out  7  inst[6:0].
- oImm  out  XLEN  sign-extended immediate.
- oCurPc  out  XLEN  PC of decoded instruction.
- oInstType  out  6  one-hot: 000001 R, 000010 I, 000100 S, 001000 B, 010000 U, 100000 J; 0 when illegal.
- oIllegal  out  1  unrecognised encoding.
- oLevel  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- Push when iValid && oReady; oReady = !full && !iFlushPipe (combinational from registered state).
- Pop of the queue head into stage 1 occurs when the queue is non-empty and the pipeline advances.
- Advance = !(oValid && !iReady). All stages shift together. A stall holds every stage and all outputs stable.
- Push while full is impossible, even if a pop happens the same cycle. Push and pop in the same cycle keep oLevel unchanged.
- Read/write pointers wrap modulo DEPTH. oLevel ranges 0..DEPTH.
- Type decode:
  - R: opcode 0110011.
  - I: opcodes 0010011, 0000011, 1100111, 1110011.
  - S: opcode 0100011.
  - B: opcode 1100011.
  - U: opcodes 0110111, 0010111.
  - J: opcode 1101111.
  - Anything else, or inst[1:0] != 11, is illegal.
- Immediate construction, with inst[31] sign-extended to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and illegal: 0.
- Field extraction is raw from the instruction word regardless of type; oImm is the only field masked by type.

## Timing
- Word accepted at edge k, empty queue, no stall: oValid is high with its fields after edge k+CYCLE_NUM.
- Sustained throughput is one instruction per cycle when iReady is held high.
- iRst and iFlushPipe clear the queue, oLevel, and every stage-valid at the clock edge. An input offered in the flush cycle is dropped.
- Output values after iRst:
  - oValid, oIllegal, oLevel, oInstType: 0.
  - All fields (oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oOpcode, oImm, oCurPc): 0.
  - oReady: 1.
- Output values after a flush: oValid = 0. Field values are don't-care.
- Reset or flush mid-stall takes priority over the hold.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - An illegal word is delivered with oValid = 1, oIllegal = 1, oInstType = 0.
  - Downstream raises the exception.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - oIllegal is tied 0.
  - An illegal word is delivered as NOP: addi x0,x0,0, i.e. opcode 0010011, oInstType 000010, all addresses and oImm 0, oCurPc preserved.

## Structure
- Shared core package holds:
  - cXLEN.
  - Opcode constants.
  - The instruction-type one-hot enum.
  - The decoded-instruction struct (rs1/rs2/rd, funct3, funct7, imm, opcode, curPc, type, illegal).
  - A pure decode function used by both RTL and bench models.
- Sub-module inst_queue (DEPTH, width 32+XLEN): synchronous FIFO with push/pop/flush/level. Top level holds the CYCLE_NUM stage registers and stall logic.

## Test plan
- Single word 0xFFF10093 (addi x1,x2,-1), CYCLE_NUM=2 -> 2 edges after accept:
  - oRs1Addr=2, oRdAddr=1, oF3=0, oImm=0xFFFFFFFF, oInstType=000010.
- 0x002081B3 (add x3,x1,x2) then 0x123452B7 (lui x5,0x12345) back-to-back:
  - Consecutive oValid cycles.
  - First: rd=3, rs1=1, rs2=2, type 000001.
  - Second: rd=5, oImm=0x12345000, type 010000.
- 0xFE000EE3 (beq x0,x0,-4) with iCurPC=0x100 -> oImm=0xFFFFFFFC, type 001000, oCurPc=0x100.
- iReady held 0 while pushing DEPTH+CYCLE_NUM words:
  - oReady drops once oLevel=DEPTH.
  - Outputs stay frozen.
  - On release, all words emerge in order with no loss or duplication.
- iFlushPipe with queue at 3 entries, pipeline full and iValid high -> next cycle:
  - oValid=0, oLevel=0.
  - The offered word never appears.
- Word 0x00000000, macro on -> oIllegal=1, type 0. Macro off -> NOP fields as specified.

Source files
------------

// File: rtl/inst_decode_pipe_pkg.sv
// Shared decode definitions for inst_decode_pipe: opcodes, type encoding,
// decoded-instruction record and the pure RV32/RV64 base decode function.
package inst_decode_pipe_pkg;

   localparam int unsigned cXLEN = 64;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [5:0] {
      T_NONE = 6'b000000,
      T_R    = 6'b000001,
      T_I    = 6'b000010,
      T_S    = 6'b000100,
      T_B    = 6'b001000,
      T_U    = 6'b010000,
      T_J    = 6'b100000
   } inst_type_e;

   typedef struct packed {
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [2:0]       f3;
      logic [6:0]       f7;
      logic [cXLEN-1:0] imm;
      logic [6:0]       opcode;
      logic [cXLEN-1:0] curPc;
      inst_type_e       itype;
      logic             illegal;
   } dec_t;

   // Immediates are sign-extended to cXLEN; narrower cores take the low bits.
   function automatic dec_t decode_inst(input logic [31:0] inst, input logic [cXLEN-1:0] pc);
      dec_t d;
      d.rs1     = inst[19:15];
      d.rs2     = inst[24:20];
      d.rd      = inst[11:7];
      d.f3      = inst[14:12];
      d.f7      = inst[31:25];
      d.opcode  = inst[6:0];
      d.curPc   = pc;
      d.imm     = '0;
      d.itype   = T_NONE;
      d.illegal = 1'b0;
      if (inst[1:0] != 2'b11) begin
         d.illegal = 1'b1;
      end else begin
         case (inst[6:0])
            OP_R: d.itype = T_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
               d.itype = T_I;
               d.imm   = {{(cXLEN-12){inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
               d.itype = T_S;
               d.imm   = {{(cXLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
               d.itype = T_B;
               d.imm   = {{(cXLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
               d.itype = T_U;
               d.imm   = {{(cXLEN-32){inst[31]}}, inst[31:12], 12'b0};
            end
            OP_JAL: begin
               d.itype = T_J;
               d.imm   = {{(cXLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: d.illegal = 1'b1;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/inst_decode_pipe_queue.sv
// inst_queue: synchronous FIFO holding {pc, instruction} words for the decode stage.
module inst_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         iClk,
   input  logic                         iRst,
   input  logic                         iFlush,
   input  logic                         iPush,
   input  logic                         iPop,
   input  logic [WIDTH-1:0]             iData,
   output logic [WIDTH-1:0]             oData,
   output logic                         oFull,
   output logic                         oEmpty,
   output logic [$clog2(DEPTH+1)-1:0]   oLevel
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic [LW-1:0]    level;
   logic             do_push;
   logic             do_pop;

   assign oFull   = (level == LW'(DEPTH));
   assign oEmpty  = (level == '0);
   assign oLevel  = level;
   assign oData   = mem[rp];
   assign do_push = iPush && !oFull;
   assign do_pop  = iPop && !oEmpty;

   always_ff @(posedge iClk) begin
      if (iRst || iFlush) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (do_push) wp <= wp + PW'(1);
         if (do_pop)  rp <= rp + PW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (do_push && !iRst && !iFlush) mem[wp] <= iData;
   end

endmodule

// File: rtl/inst_decode_pipe.sv
// Elastic decode stage: input queue followed by CYCLE_NUM decode registers.
// DECODE_ILLEGAL_TRAP_EN: deliver illegal words flagged; otherwise replace with NOP.
module inst_decode_pipe
   import inst_decode_pipe_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CYCLE_NUM = 2
) (
   input  logic                        iClk,
   input  logic                        iRst,
   input  logic [31:0]                 iInst,
   input  logic [XLEN-1:0]             iCurPC,
   input  logic                        iValid,
   output logic                        oReady,
   input  logic                        iFlushPipe,
   input  logic                        iReady,
   output logic                        oValid,
   output logic [4:0]                  oRs1Addr,
   output logic [4:0]                  oRs2Addr,
   output logic [4:0]                  oRdAddr,
   output logic [2:0]                  oF3,
   output logic [6:0]                  oF7,
   output logic [6:0]                  oOpcode,
   output logic [XLEN-1:0]             oImm,
   output logic [XLEN-1:0]             oCurPc,
   output logic [5:0]                  oInstType,
   output logic                        oIllegal,
   output logic [$clog2(DEPTH+1)-1:0]  oLevel
);

   logic [XLEN+31:0]       q_rdata;
   logic                   q_full;
   logic                   q_empty;
   logic                   push;
   logic                   pop;
   logic                   advance;
   logic [CYCLE_NUM-1:0]   vld;
   dec_t                   stg [CYCLE_NUM];
   dec_t                   dec_in;
   dec_t                   last;

   assign oReady  = !q_full && !iFlushPipe;
   assign push    = iValid && oReady;
   assign oValid  = vld[CYCLE_NUM-1];
   assign advance = !(oValid && !iReady);
   assign pop     = !q_empty && advance && !iFlushPipe;

   inst_queue #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN+32)
   ) u_queue (
      .iClk   (iClk),
      .iRst   (iRst),
      .iFlush (iFlushPipe),
      .iPush  (push),
      .iPop   (pop),
      .iData  ({iCurPC, iInst}),
      .oData  (q_rdata),
      .oFull  (q_full),
      .oEmpty (q_empty),
      .oLevel (oLevel)
   );

   always_comb begin
      dec_in = decode_inst(q_rdata[31:0], cXLEN'(q_rdata[XLEN+31:32]));
`ifndef DECODE_ILLEGAL_TRAP_EN
      if (dec_in.illegal) begin
         dec_in.rs1     = '0;
         dec_in.rs2     = '0;
         dec_in.rd      = '0;
         dec_in.f3      = '0;
         dec_in.f7      = '0;
         dec_in.imm     = '0;
         dec_in.opcode  = OP_IMM;
         dec_in.itype   = T_I;
         dec_in.illegal = 1'b0;
      end
`endif
   end

   // Stage payloads load only with a valid word so outputs keep the last delivery.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         vld <= '0;
         for (int unsigned i = 0; i < CYCLE_NUM; i++) stg[i] <= '0;
      end else if (iFlushPipe) begin
         vld <= '0;
      end else if (advance) begin
         vld[0] <= pop;
         if (pop) stg[0] <= dec_in;
         for (int unsigned i = 1; i < CYCLE_NUM; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) stg[i] <= stg[i-1];
         end
      end
   end

   assign last      = stg[CYCLE_NUM-1];
   assign oRs1Addr  = last.rs1;
   assign oRs2Addr  = last.rs2;
   assign oRdAddr   = last.rd;
   assign oF3       = last.f3;
   assign oF7       = last.f7;
   assign oOpcode   = last.opcode;
   assign oImm      = last.imm[XLEN-1:0];
   assign oCurPc    = last.curPc[XLEN-1:0];
   assign oInstType = last.itype;

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign oIllegal = last.illegal;
`else
   logic unused_illegal;
   assign oIllegal       = 1'b0;
   assign unused_illegal = last.illegal;
`endif

   if (XLEN < cXLEN) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^{last.imm[cXLEN-1:XLEN], last.curPc[cXLEN-1:XLEN]};
   end

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed scoreboard bench for inst_decode_pipe (XLEN=32, DEPTH=4, CYCLE_NUM=2).
module tb_inst_decode_pipe;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic [31:0] iInst = '0;
   logic [31:0] iCurPC = '0;
   logic        iValid = 1'b0;
   logic        oReady;
   logic        iFlushPipe = 1'b0;
   logic        iReady = 1'b1;
   logic        oValid;
   logic [4:0]  oRs1Addr, oRs2Addr, oRdAddr;
   logic [2:0]  oF3;
   logic [6:0]  oF7, oOpcode;
   logic [31:0] oImm, oCurPc;
   logic [5:0]  oInstType;
   logic        oIllegal;
   logic [2:0]  oLevel;

   typedef struct {
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7, op;
      logic [31:0] imm, pc;
      logic [5:0]  ty;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   out_count = 0;

   always #5 iClk = ~iClk;

   inst_decode_pipe #(.XLEN(32), .DEPTH(4), .CYCLE_NUM(2)) dut (
      .iClk(iClk), .iRst(iRst), .iInst(iInst), .iCurPC(iCurPC), .iValid(iValid),
      .oReady(oReady), .iFlushPipe(iFlushPipe), .iReady(iReady), .oValid(oValid),
      .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr), .oRdAddr(oRdAddr), .oF3(oF3), .oF7(oF7),
      .oOpcode(oOpcode), .oImm(oImm), .oCurPc(oCurPc), .oInstType(oInstType),
      .oIllegal(oIllegal), .oLevel(oLevel)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [5:0] ty, input logic ill);
      exp_t e;
      e.rd = inst[11:7];   e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
      e.f3 = inst[14:12];  e.f7 = inst[31:25];  e.op = inst[6:0];
      e.imm = imm; e.pc = pc; e.ty = ty; e.ill = ill;
      return e;
   endfunction

   always @(negedge iClk) begin
      if (!iRst && oValid && iReady) begin
         exp_t e;
         out_count++;
         chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rd", 64'(oRdAddr), 64'(e.rd));
            chk("rs1", 64'(oRs1Addr), 64'(e.rs1));
            chk("rs2", 64'(oRs2Addr), 64'(e.rs2));
            chk("f3", 64'(oF3), 64'(e.f3));
            chk("f7", 64'(oF7), 64'(e.f7));
            chk("opcode", 64'(oOpcode), 64'(e.op));
            chk("imm", 64'(oImm), 64'(e.imm));
            chk("pc", 64'(oCurPc), 64'(e.pc));
            chk("type", 64'(oInstType), 64'(e.ty));
            chk("illegal", 64'(oIllegal), 64'(e.ill));
         end
      end
   end

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
      logic ok = 1'b0;
      iInst = inst; iCurPC = pc; iValid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge iClk);
         ok = oReady;
         step();
      end
      iValid = 1'b0;
      chk("send_accepted", 64'(ok), 64'd1);
      if (ok) sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 100 && sb.size() != 0; n++) step();
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int base;
      exp_t e;
      logic signed [31:0] v;

      repeat (3) step();
      iRst = 1'b0;
      @(negedge iClk);
      chk("rst_valid", 64'(oValid), 64'd0);
      chk("rst_level", 64'(oLevel), 64'd0);
      chk("rst_ready", 64'(oReady), 64'd1);
      chk("rst_type", 64'(oInstType), 64'd0);
      chk("rst_illegal", 64'(oIllegal), 64'd0);
      chk("rst_fields", 64'({oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oOpcode}), 64'd0);
      chk("rst_imm_pc", {oImm, oCurPc}, 64'd0);
      step();

      // addi x1,x2,-1: visible exactly two edges after acceptance
      send(32'hFFF10093, 32'h0, mk(32'hFFF10093, 32'h0, 32'hFFFFFFFF, 6'b000010, 1'b0));
      @(negedge iClk); chk("lat_k", 64'(oValid), 64'd0);
      step(); @(negedge iClk); chk("lat_k1", 64'(oValid), 64'd0);
      step(); @(negedge iClk); chk("lat_k2", 64'(oValid), 64'd1);
      drain("drain_addi");

      // add then lui back-to-back
      send(32'h002081B3, 32'h4, mk(32'h002081B3, 32'h4, 32'h0, 6'b000001, 1'b0));
      send(32'h123452B7, 32'h8, mk(32'h123452B7, 32'h8, 32'h12345000, 6'b010000, 1'b0));
      begin
         logic seen = 1'b0;
         for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge iClk);
            seen = oValid;
            if (!seen) step();
         end
         chk("b2b_first", 64'(seen), 64'd1);
         step(); @(negedge iClk);
         chk("b2b_second", 64'(oValid), 64'd1);
      end
      drain("drain_b2b");

      send(32'hFE000EE3, 32'h100, mk(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 6'b001000, 1'b0));
      send(32'hFE512C23, 32'h104, mk(32'hFE512C23, 32'h104, 32'hFFFFFFF8, 6'b000100, 1'b0));
      send(32'h010000EF, 32'h108, mk(32'h010000EF, 32'h108, 32'h00000010, 6'b100000, 1'b0));
      drain("drain_bsj");

      // Backpressure: DEPTH+CYCLE_NUM words with iReady low
      iReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [31:0] inst;
         v = 32'(i * 100 - 250);
         inst = {v[11:0], 5'(i + 7), 3'b000, 5'(i + 1), 7'b0010011};
         send(inst, 32'h400 + 32'(i * 4), mk(inst, 32'h400 + 32'(i * 4), v, 6'b000010, 1'b0));
      end
      @(negedge iClk);
      chk("stall_level_full", 64'(oLevel), 64'd4);
      chk("stall_ready_low", 64'(oReady), 64'd0);
      repeat (4) step();
      @(negedge iClk);
      chk("stall_valid", 64'(oValid), 64'd1);
      chk("stall_rd", 64'(oRdAddr), 64'(sb[0].rd));
      chk("stall_imm", 64'(oImm), 64'(sb[0].imm));
      chk("stall_pc", 64'(oCurPc), 64'(sb[0].pc));
      chk("stall_level_hold", 64'(oLevel), 64'd4);
      step();
      iReady = 1'b1;
      drain("drain_stall");
      repeat (3) step();

      // Flush with 3 queued, pipeline full, a word offered in the flush cycle
      iReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(32'h00000013 | (32'(i + 10) << 7), 32'h800 + 32'(i * 4),
              mk(32'h00000013 | (32'(i + 10) << 7), 32'h800 + 32'(i * 4), 32'h0, 6'b000010, 1'b0));
      end
      @(negedge iClk);
      chk("pre_flush_level", 64'(oLevel), 64'd3);
      chk("pre_flush_valid", 64'(oValid), 64'd1);
      step();
      sb.delete();
      base = out_count;
      iFlushPipe = 1'b1; iValid = 1'b1; iInst = 32'h7FF00F93; iCurPC = 32'hBAD0;
      step();
      iFlushPipe = 1'b0; iValid = 1'b0;
      @(negedge iClk);
      chk("flush_valid", 64'(oValid), 64'd0);
      chk("flush_level", 64'(oLevel), 64'd0);
      chk("flush_ready", 64'(oReady), 64'd1);
      iReady = 1'b1;
      repeat (10) step();
      chk("flush_no_output", 64'(out_count), 64'(base));

      // All-zero word: illegal
`ifdef DECODE_ILLEGAL_TRAP_EN
      e = mk(32'h00000000, 32'h200, 32'h0, 6'b000000, 1'b1);
`else
      e = mk(32'h00000013, 32'h200, 32'h0, 6'b000010, 1'b0);
`endif
      send(32'h00000000, 32'h200, e);
      drain("drain_illegal");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
